// File: rtl/gvp_vector_engine_if.sv
// Program-load bus and scan/trigger outputs of the GVP vector engine.
interface gvp_vector_engine_if;
  logic         setvec;
  logic [511:0] vp_set;
  logic [31:0]  x;
  logic [31:0]  y;
  logic [31:0]  z;
  logic [31:0]  u;
  logic [31:0]  options;
  logic [31:0]  section;
  logic [1:0]   store_data;
  logic         gvp_finished;

  modport master (
    output setvec, vp_set,
    input  x, y, z, u, options, section, store_data, gvp_finished
  );

  modport slave (
    input  setvec, vp_set,
    output x, y, z, u, options, section, store_data, gvp_finished
  );
endinterface

// File: rtl/gvp_vector_engine.sv
// GVP sequencer: steps signed x/y/z/u accumulators through programmed vector sections.
// Optional section-header trigger (store_data=2) is enabled by defining GVP_HEADER_STORE_EN.
module gvp_vector_engine #(
  parameter int VADR_BITS = 4
) (
  input  logic               clk,
  input  logic               resetn,
  gvp_vector_engine_if.slave bus
);
  localparam int DEPTH = 1 << VADR_BITS;

  // LOAD fetch mem[pc] | HEADER section pulse | POINT step accumulators | NEXT loop/jump | FIN done
  localparam logic [2:0] ST_LOAD   = 3'd0;
`ifdef GVP_HEADER_STORE_EN
  localparam logic [2:0] ST_HEADER = 3'd1;
`endif
  localparam logic [2:0] ST_POINT  = 3'd2;
  localparam logic [2:0] ST_NEXT   = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  logic [31:0]          mem_n_q    [DEPTH];
  logic [31:0]          mem_nii_q  [DEPTH];
  logic [31:0]          mem_opt_q  [DEPTH];
  logic [31:0]          mem_nrep_q [DEPTH];
  logic [VADR_BITS-1:0] mem_next_q [DEPTH];
  logic [31:0]          mem_dx_q   [DEPTH];
  logic [31:0]          mem_dy_q   [DEPTH];
  logic [31:0]          mem_dz_q   [DEPTH];
  logic [31:0]          mem_du_q   [DEPTH];

  logic [VADR_BITS-1:0] wadr;
  logic                 unused_vp_bits;

  assign wadr           = bus.vp_set[VADR_BITS-1:0];
  assign unused_vp_bits = ^{bus.vp_set[511:320], bus.vp_set[31:VADR_BITS]};

  // Program memory has no reset so contents survive a hold/abort.
  always_ff @(posedge clk) begin
    if (bus.setvec) begin
      mem_n_q[wadr]    <= bus.vp_set[63:32];
      mem_nii_q[wadr]  <= bus.vp_set[95:64];
      mem_opt_q[wadr]  <= bus.vp_set[127:96];
      mem_nrep_q[wadr] <= bus.vp_set[159:128];
      mem_next_q[wadr] <= bus.vp_set[160 +: VADR_BITS];
      mem_dx_q[wadr]   <= bus.vp_set[223:192];
      mem_dy_q[wadr]   <= bus.vp_set[255:224];
      mem_dz_q[wadr]   <= bus.vp_set[287:256];
      mem_du_q[wadr]   <= bus.vp_set[319:288];
    end
  end

  logic [2:0]           state_q, state_d;
  logic [VADR_BITS-1:0] pc_q, pc_d;
  logic [31:0]          x_q, x_d, y_q, y_d, z_q, z_d, u_q, u_d;
  logic [31:0]          options_q, options_d, section_q, section_d;
  logic [1:0]           store_q, store_d;
  logic                 fin_q, fin_d;
  logic [31:0]          npts_q, npts_d, dly_q, dly_d, nii_q, nii_d;
  logic [31:0]          rep_q [DEPTH];
  logic [31:0]          rep_d [DEPTH];
  logic [DEPTH-1:0]     armed_q, armed_d;

  logic [31:0]          cur_n, cur_nii, cur_opt, cur_nrep;
  logic [VADR_BITS-1:0] cur_next;

  assign cur_n    = mem_n_q[pc_q];
  assign cur_nii  = mem_nii_q[pc_q];
  assign cur_opt  = mem_opt_q[pc_q];
  assign cur_nrep = mem_nrep_q[pc_q];
  assign cur_next = mem_next_q[pc_q];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    u_d       = u_q;
    options_d = options_q;
    section_d = section_q;
    store_d   = 2'd0;
    fin_d     = fin_q;
    npts_d    = npts_q;
    dly_d     = dly_q;
    nii_d     = nii_q;
    rep_d     = rep_q;
    armed_d   = armed_q;

    case (state_q)
      ST_LOAD: begin
        section_d = 32'(pc_q);
        if (cur_n == 32'd0) begin
          state_d = ST_FIN;
          fin_d   = 1'b1;
        end else begin
          options_d = cur_opt;
          npts_d    = cur_n;
          dly_d     = cur_nii;
          nii_d     = cur_nii;
          if (!armed_q[pc_q]) begin
            rep_d[pc_q]   = cur_nrep;
            armed_d[pc_q] = 1'b1;
          end
`ifdef GVP_HEADER_STORE_EN
          state_d = ST_HEADER;
`else
          state_d = ST_POINT;
`endif
        end
      end
`ifdef GVP_HEADER_STORE_EN
      ST_HEADER: begin
        store_d = 2'd2;
        state_d = ST_POINT;
      end
`endif
      ST_POINT: begin
        if (dly_q != 32'd0) begin
          dly_d = dly_q - 32'd1;
        end else begin
          x_d     = x_q + mem_dx_q[pc_q];
          y_d     = y_q + mem_dy_q[pc_q];
          z_d     = z_q + mem_dz_q[pc_q];
          u_d     = u_q + mem_du_q[pc_q];
          store_d = 2'd1;
          npts_d  = npts_q - 32'd1;
          dly_d   = nii_q;
          if (npts_q == 32'd1) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // Next is sign-extended; adding its low bits wraps modulo depth.
        if (cur_nrep != 32'd0 && rep_q[pc_q] != 32'd0) begin
          rep_d[pc_q] = rep_q[pc_q] - 32'd1;
          pc_d        = pc_q + cur_next;
        end else begin
          rep_d[pc_q] = cur_nrep;
          pc_d        = pc_q + VADR_BITS'(1);
        end
        state_d = ST_LOAD;
      end
      ST_FIN: begin
        state_d = ST_FIN;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_LOAD;
      pc_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      u_q       <= '0;
      options_q <= '0;
      section_q <= '0;
      store_q   <= '0;
      fin_q     <= 1'b0;
      npts_q    <= '0;
      dly_q     <= '0;
      nii_q     <= '0;
      rep_q     <= '{default: '0};
      armed_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      u_q       <= u_d;
      options_q <= options_d;
      section_q <= section_d;
      store_q   <= store_d;
      fin_q     <= fin_d;
      npts_q    <= npts_d;
      dly_q     <= dly_d;
      nii_q     <= nii_d;
      rep_q     <= rep_d;
      armed_q   <= armed_d;
    end
  end

  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.z            = z_q;
  assign bus.u            = u_q;
  assign bus.options      = options_q;
  assign bus.section      = section_q;
  assign bus.store_data   = store_q;
  assign bus.gvp_finished = fin_q;
endmodule

// File: tb/tb_gvp_vector_engine.sv
// Scoreboard bench for gvp_vector_engine: a section-level reference model predicts every
// store_data pulse (kind, cycle, outputs) and the final state of each program run.
module tb_gvp_vector_engine;
`ifdef GVP_HEADER_STORE_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b1;
  gvp_vector_engine_if bus ();

  gvp_vector_engine #(.VADR_BITS(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  typedef struct {
    logic [1:0]  kind;
    int          cyc;
    logic [31:0] x, y, z, u, opt, sec;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  misc = 0;
  int  obs_hdr, obs_pts;

  bit [31:0] m_n[16], m_nii[16], m_opt[16], m_nrep[16], m_next[16];
  bit [31:0] m_dx[16], m_dy[16], m_dz[16], m_du[16];

  int        e_fin_cyc, e_hdr, e_pts;
  bit [31:0] e_x, e_y, e_z, e_u, e_opt, e_sec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every trigger pulse must match the oldest predicted event.
  always @(negedge clk) begin
    if (resetn && bus.store_data != 2'd0) begin
      ev_t e;
      if (bus.store_data == 2'd2) obs_hdr++;
      else                        obs_pts++;
      vectors++;
      if (exp_q.size() == 0) begin
        misc++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected no pulse", bus.store_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== bus.store_data || e.cyc != cyc || e.x !== bus.x || e.y !== bus.y ||
            e.z !== bus.z || e.u !== bus.u || e.opt !== bus.options || e.sec !== bus.section) begin
          misc++;
          $display("FAIL pulse: got k=%0d c=%0d x=%h y=%h z=%h u=%h o=%h s=%h expected k=%0d c=%0d x=%h y=%h z=%h u=%h o=%h s=%h",
                   bus.store_data, cyc, bus.x, bus.y, bus.z, bus.u, bus.options, bus.section,
                   e.kind, e.cyc, e.x, e.y, e.z, e.u, e.opt, e.sec);
        end
      end
    end
  end

  task automatic write_sec(input logic [31:0] vadr, input logic [31:0] n, input logic [31:0] nii,
                           input logic [31:0] opt, input logic [31:0] nrep, input logic [31:0] nxt,
                           input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] dz,
                           input logic [31:0] du);
    int idx;
    idx = int'(vadr[3:0]);
    @(negedge clk);
    bus.vp_set[31:0]    = vadr;
    bus.vp_set[63:32]   = n;
    bus.vp_set[95:64]   = nii;
    bus.vp_set[127:96]  = opt;
    bus.vp_set[159:128] = nrep;
    bus.vp_set[191:160] = nxt;
    bus.vp_set[223:192] = dx;
    bus.vp_set[255:224] = dy;
    bus.vp_set[287:256] = dz;
    bus.vp_set[319:288] = du;
    bus.vp_set[511:320] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    bus.setvec = 1'b1;
    @(negedge clk);
    bus.setvec = 1'b0;
    m_n[idx] = n;    m_nii[idx] = nii; m_opt[idx] = opt; m_nrep[idx] = nrep; m_next[idx] = nxt;
    m_dx[idx] = dx;  m_dy[idx] = dy;   m_dz[idx] = dz;   m_du[idx] = du;
  endtask

  // Section-level model: cycle numbers count clock edges after resetn rises.
  task automatic model_run();
    bit [31:0] rep[16];
    bit        armed[16];
    int        pc = 0, t = 1, guard = 0;
    e_x = 0; e_y = 0; e_z = 0; e_u = 0; e_opt = 0; e_sec = 0;
    e_hdr = 0; e_pts = 0;
    for (int i = 0; i < 16; i++) begin rep[i] = 0; armed[i] = 1'b0; end
    forever begin
      e_sec = 32'(pc);
      if (m_n[pc] == 0) begin e_fin_cyc = t; break; end
      e_opt = m_opt[pc];
      if (!armed[pc]) begin rep[pc] = m_nrep[pc]; armed[pc] = 1'b1; end
      if (HDR) begin
        t++;
        exp_q.push_back('{2'd2, t, e_x, e_y, e_z, e_u, e_opt, e_sec});
        e_hdr++;
      end
      for (int k = 0; k < int'(m_n[pc]); k++) begin
        t += int'(m_nii[pc]) + 1;
        e_x += m_dx[pc]; e_y += m_dy[pc]; e_z += m_dz[pc]; e_u += m_du[pc];
        exp_q.push_back('{2'd1, t, e_x, e_y, e_z, e_u, e_opt, e_sec});
        e_pts++;
      end
      t += 2;
      if (m_nrep[pc] != 0 && rep[pc] != 0) begin
        rep[pc]--;
        pc = (pc + int'(m_next[pc])) & 15;
      end else begin
        rep[pc] = m_nrep[pc];
        pc = (pc + 1) & 15;
      end
      guard++;
      if (guard > 500) begin e_fin_cyc = t; break; end
    end
  endtask

  task automatic run_prog(input string nm);
    bit seen = 1'b0;
    int seen_cyc = 0;
    exp_q.delete();
    model_run();
    obs_hdr = 0; obs_pts = 0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < e_fin_cyc + 20; i++) begin
      @(negedge clk);
      if (bus.gvp_finished) begin seen = 1'b1; seen_cyc = cyc; break; end
    end
    chk({nm, "_finished"}, 32'(seen), 32'd1);
    chk({nm, "_fin_cycle"}, 32'(seen_cyc), 32'(e_fin_cyc));
    repeat (3) @(negedge clk);
    chk({nm, "_x"}, bus.x, e_x);
    chk({nm, "_y"}, bus.y, e_y);
    chk({nm, "_z"}, bus.z, e_z);
    chk({nm, "_u"}, bus.u, e_u);
    chk({nm, "_section"}, bus.section, e_sec);
    chk({nm, "_options"}, bus.options, e_opt);
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_pts"}, 32'(obs_pts), 32'(e_pts));
    chk({nm, "_hdrs"}, 32'(obs_hdr), 32'(e_hdr));
    resetn = 1'b0;
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_x0"}, bus.x, 32'd0);
    chk({nm, "_y0"}, bus.y, 32'd0);
    chk({nm, "_z0"}, bus.z, 32'd0);
    chk({nm, "_u0"}, bus.u, 32'd0);
    chk({nm, "_sd0"}, 32'(bus.store_data), 32'd0);
    chk({nm, "_fin0"}, 32'(bus.gvp_finished), 32'd0);
    chk({nm, "_sec0"}, bus.section, 32'd0);
  endtask

  initial begin
    bus.setvec = 1'b0;
    bus.vp_set = '0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    chk("reset_opt", bus.options, 32'd0);

    // Single section, then END.
    write_sec(0, 5, 128, 1, 0, 0, -32'sd2, -32'sd2, 0, 0);
    write_sec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_prog("basic");
    chk("basic_x_spec", bus.x, 32'hFFFF_FFF6);
    chk("basic_y_spec", bus.y, 32'hFFFF_FFF6);
    chk("basic_pts_spec", 32'(obs_pts), 32'd5);
    chk("basic_hdr_spec", 32'(obs_hdr), HDR ? 32'd1 : 32'd0);

    // Raster: abort mid-run, then rerun from retained memory.
    write_sec(0, 10, 128, 0, 0, 0, 256, 0, 0, 0);
    write_sec(1, 10, 128, 0, 0, 0, -32'sd256, 0, 0, 0);
    write_sec(2, 1, 128, 0, 10, -32'sd2, 0, 64, 0, 0);
    write_sec(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.delete();
    model_run();
    @(negedge clk);
    resetn = 1'b1;
    repeat (1500) @(negedge clk);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 chk_cleared("abort");
    exp_q.delete();
    run_prog("raster");
    chk("raster_pts_spec", 32'(obs_pts), 32'd231);
    chk("raster_hdr_spec", 32'(obs_hdr), HDR ? 32'd33 : 32'd0);
    chk("raster_y_spec", bus.y, 32'd704);
    chk("raster_x_spec", bus.x, 32'd0);
    chk("raster_sec_spec", bus.section, 32'd3);

    // Back-to-back points with wrap.
    write_sec(0, 4, 0, 0, 0, 0, 0, 0, 0, 32'h7FFF_FFFF);
    write_sec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_prog("wrap");
    chk("wrap_u_spec", bus.u, 32'hFFFF_FFFC);

    // Self-loop; second run shows rep counters re-arm after reset.
    write_sec(0, 3, 2, 5, 2, 0, 0, 0, 1, 0);
    for (int r = 0; r < 2; r++) begin
      run_prog("selfloop");
      chk("selfloop_z_spec", bus.z, 32'd9);
      chk("selfloop_hdr_spec", 32'(obs_hdr), HDR ? 32'd3 : 32'd0);
    end

    // Upper vadr bits ignored: 0x13 lands in section 3.
    write_sec(32'h13, 2, 1, 7, 0, 0, 5, 0, 0, 0);
    write_sec(0, 1, 0, 2, 1, 3, 1, 0, 0, 0);
    write_sec(4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_prog("vadr");
    chk("vadr_x_spec", bus.x, 32'd11);

    write_sec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_prog("endonly");
    chk("endonly_pulses", 32'(obs_pts + obs_hdr), 32'd0);

    // Randomised small programs with forward steps and backward loops.
    for (int it = 0; it < 4; it++) begin
      for (int s = 0; s < 3; s++) begin
        write_sec(32'(s), $urandom_range(1, 4), $urandom_range(0, 3), $urandom(),
                  $urandom_range(0, 2), -$urandom_range(0, s),
                  $urandom(), $urandom(), $urandom(), $urandom());
      end
      write_sec(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_prog("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule
